// File: rtl/mem_arb_pkg.sv
// Shared types, grant constants and width helpers for the memory-port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states. IDLE samples requests and RELEASE is the one-cycle
  // gap after a completion.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IC_RD   = 3'd1,
    DC_RD   = 3'd2,
    DC_WR   = 3'd3,
    RELEASE = 3'd4
  } arb_state_e;

  // Requester identities. These values also index the 2-bit request vector.
  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  // Block width in bits: words per block times word width.
  function automatic int blk_width(input int line_size, input int block_bits);
    return (2 ** block_bits) * line_size;
  endfunction

  // Block address width: the byte address without the word and byte offsets.
  function automatic int addr_width(input int addr_size, input int block_bits);
    return addr_size - block_bits - 2;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. Bit 0 is the icache and bit 1 is the dcache.
// On a tie, the requester that was not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      localparam logic SELF = 1'(gi);
      // A slot wins if it requests and either the other slot is quiet or this slot was not served last.
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant != SELF));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port between icache refills and dcache
// refills or writebacks. Only one transaction is in flight at a time. The grant
// is held until memory reports completion, and a one-cycle RELEASE gap follows.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int LINE_SIZE  = 32,
  parameter  int BLOCK_BITS = 2,
  parameter  int ADDR_SIZE  = 32,
  localparam int BW         = blk_width(LINE_SIZE, BLOCK_BITS),
  localparam int AW         = addr_width(ADDR_SIZE, BLOCK_BITS)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  // icache port
  input  logic          ic_read_en_i,
  input  logic [AW-1:0] ic_address_i,
  output logic [BW-1:0] ic_read_data_o,
  output logic          ic_busywait_o,
  output logic          ic_read_done_o,
  // dcache port
  input  logic          dc_read_en_i,
  input  logic          dc_write_en_i,
  input  logic [AW-1:0] dc_address_i,
  input  logic [BW-1:0] dc_write_data_i,
  output logic [BW-1:0] dc_read_data_o,
  output logic          dc_busywait_o,
  output logic          dc_read_done_o,
  output logic          dc_write_done_o,
  // memory port
  output logic          m_read_en_o,
  output logic          m_write_en_o,
  output logic [AW-1:0] m_address_o,
  output logic [BW-1:0] m_write_data_o,
  input  logic [BW-1:0] m_read_data_i,
  input  logic          m_busywait_i,
  input  logic          m_read_done_i,
  input  logic          m_write_done_i
);

  arb_state_e state_reg;
  logic       last_grant_reg;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       dc_req;
  logic       rd_ok;
  logic       wr_ok;
  logic       ic_granted;
  logic       dc_granted;
  logic       dc_done;

  // A dcache writeback and a dcache refill share one arbitration slot.
  assign dc_req = dc_read_en_i | dc_write_en_i;
  assign req    = {dc_req, ic_read_en_i};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_reg),
    .gnt        (gnt)
  );

  // Memory completions count only when memory is not busy.
  assign rd_ok = m_read_done_i & ~m_busywait_i;
  assign wr_ok = m_write_done_i & ~m_busywait_i;

  assign ic_granted = (state_reg == IC_RD);
  assign dc_granted = (state_reg == DC_RD) || (state_reg == DC_WR);

  // Done pulses are passed through in the completion cycle, but only for the
  // owner of the current transaction and only for a completion of the matching type.
  assign ic_read_done_o  = (state_reg == IC_RD) & rd_ok;
  assign dc_read_done_o  = (state_reg == DC_RD) & rd_ok;
  assign dc_write_done_o = (state_reg == DC_WR) & wr_ok;
  assign dc_done         = dc_read_done_o | dc_write_done_o;

  // Both ports see the memory read data. The done pulse tells a port whether the data is valid.
  assign ic_read_data_o = m_read_data_i;
  assign dc_read_data_o = m_read_data_i;

  // A waiting requester is always busy. The owner follows the memory port
  // until its done pulse. An idle requester is never busy.
  assign ic_busywait_o = ic_granted ? (m_busywait_i | ~ic_read_done_o) : ic_read_en_i;
  assign dc_busywait_o = dc_granted ? (m_busywait_i | ~dc_done)        : dc_req;

  // Arbitration FSM. It grants in IDLE, holds the strobe until completion and inserts one RELEASE cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_DC;
      m_read_en_o    <= 1'b0;
      m_write_en_o   <= 1'b0;
      m_address_o    <= '0;
      m_write_data_o <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt[GRANT_IC]) begin
            state_reg      <= IC_RD;
            last_grant_reg <= GRANT_IC;
            m_read_en_o    <= 1'b1;
            m_address_o    <= ic_address_i;
          end else if (gnt[GRANT_DC]) begin
            last_grant_reg <= GRANT_DC;
            m_address_o    <= dc_address_i;
            // A writeback takes precedence over a refill, even if both are requested.
            if (dc_write_en_i) begin
              state_reg      <= DC_WR;
              m_write_en_o   <= 1'b1;
              m_write_data_o <= dc_write_data_i;
            end else begin
              state_reg   <= DC_RD;
              m_read_en_o <= 1'b1;
            end
          end
        end
        IC_RD, DC_RD: begin
          if (rd_ok) begin
            state_reg   <= RELEASE;
            m_read_en_o <= 1'b0;
          end
        end
        DC_WR: begin
          if (wr_ok) begin
            state_reg    <= RELEASE;
            m_write_en_o <= 1'b0;
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg    <= IDLE;
          m_read_en_o  <= 1'b0;
          m_write_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector tables, hand-written
// corner sequences, and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int BW = 128;
  localparam int AW = 28;

  logic          clk_i     = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          ic_read_en_i = 1'b0;
  logic [AW-1:0] ic_address_i = '0;
  logic [BW-1:0] ic_read_data_o;
  logic          ic_busywait_o;
  logic          ic_read_done_o;
  logic          dc_read_en_i = 1'b0;
  logic          dc_write_en_i = 1'b0;
  logic [AW-1:0] dc_address_i = '0;
  logic [BW-1:0] dc_write_data_i = '0;
  logic [BW-1:0] dc_read_data_o;
  logic          dc_busywait_o;
  logic          dc_read_done_o;
  logic          dc_write_done_o;
  logic          m_read_en_o;
  logic          m_write_en_o;
  logic [AW-1:0] m_address_o;
  logic [BW-1:0] m_write_data_o;
  logic [BW-1:0] m_read_data_i = '0;
  logic          m_busywait_i = 1'b0;
  logic          m_read_done_i = 1'b0;
  logic          m_write_done_i = 1'b0;

  // Order of the bits in ctl: {ic_done, dc_rd_done, dc_wr_done, ic_bw, dc_bw, m_ren, m_wen}
  logic [6:0] ctl;
  assign ctl = {ic_read_done_o, dc_read_done_o, dc_write_done_o,
                ic_busywait_o, dc_busywait_o, m_read_en_o, m_write_en_o};

  int total = 0;
  int bad   = 0;

  // Order of the bits in in_bits: {ic_en, dc_rd, dc_wr, m_busy, m_rdone, m_wdone}
  typedef struct packed {
    logic [5:0]    in_bits;
    logic [6:0]    exp_bits;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t tbl [21];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .LINE_SIZE  (32),
    .BLOCK_BITS (2),
    .ADDR_SIZE  (32)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .ic_read_en_i    (ic_read_en_i),
    .ic_address_i    (ic_address_i),
    .ic_read_data_o  (ic_read_data_o),
    .ic_busywait_o   (ic_busywait_o),
    .ic_read_done_o  (ic_read_done_o),
    .dc_read_en_i    (dc_read_en_i),
    .dc_write_en_i   (dc_write_en_i),
    .dc_address_i    (dc_address_i),
    .dc_write_data_i (dc_write_data_i),
    .dc_read_data_o  (dc_read_data_o),
    .dc_busywait_o   (dc_busywait_o),
    .dc_read_done_o  (dc_read_done_o),
    .dc_write_done_o (dc_write_done_o),
    .m_read_en_o     (m_read_en_o),
    .m_write_en_o    (m_write_en_o),
    .m_address_o     (m_address_o),
    .m_write_data_o  (m_write_data_o),
    .m_read_data_i   (m_read_data_i),
    .m_busywait_i    (m_busywait_i),
    .m_read_done_i   (m_read_done_i),
    .m_write_done_i  (m_write_done_i)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] b);
    {ic_read_en_i, dc_read_en_i, dc_write_en_i, m_busywait_i, m_read_done_i, m_write_done_i} = b;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    set_in(6'b000000);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    chk("reset_ctl", 128'(ctl), 128'(7'b0000000));
    chk("reset_addr", 128'(m_address_o), 128'(0));
    chk("reset_wdata", m_write_data_o, 128'(0));
  endtask

  // Applies one cycle of stimulus and checks the outputs of that cycle.
  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk_i);
    set_in(v.in_bits);
    #1;
    chk({name, "_ctl"}, 128'(ctl), 128'(v.exp_bits));
    chk({name, "_addr"}, 128'(m_address_o), 128'(v.exp_addr));
    if (v.exp_bits[6]) chk({name, "_icdata"}, ic_read_data_o, m_read_data_i);
    if (v.exp_bits[5]) chk({name, "_dcdata"}, dc_read_data_o, m_read_data_i);
    if (v.exp_bits[0]) chk({name, "_wdata"}, m_write_data_o, dc_write_data_i);
    $display("%s in=%b ctl=%b addr=%h", name, v.in_bits, ctl, m_address_o);
  endtask

  initial begin
    int         owner;   // 0 none, 1 icache, 2 dcache
    int         last;    // 1 icache, 2 dcache
    bit         rel;
    bit         own_wr;
    bit         e_ren, e_wen, e_icd, e_drd, e_dwd, e_icb, e_dcb, rok, wok;
    bit         ic_act, dc_act, dc_wr_pick, dc_both;
    logic [AW-1:0]  e_addr;
    logic [BW-1:0]  e_wdata;
    int         ntx;

    // Directed table: icache alone, done inputs while idle, dcache writeback then refill, write+read together.
    tbl[0]  = '{6'b100000, 7'b0001000, 28'h0};
    tbl[1]  = '{6'b100100, 7'b0001010, 28'h10};
    tbl[2]  = '{6'b100100, 7'b0001010, 28'h10};
    tbl[3]  = '{6'b100100, 7'b0001010, 28'h10};
    tbl[4]  = '{6'b100100, 7'b0001010, 28'h10};
    tbl[5]  = '{6'b100010, 7'b1000010, 28'h10};
    tbl[6]  = '{6'b000000, 7'b0000000, 28'h10};
    tbl[7]  = '{6'b000010, 7'b0000000, 28'h10};
    tbl[8]  = '{6'b001000, 7'b0000100, 28'h10};
    tbl[9]  = '{6'b001010, 7'b0000101, 28'hFF};
    tbl[10] = '{6'b001101, 7'b0000101, 28'hFF};
    tbl[11] = '{6'b001001, 7'b0010001, 28'hFF};
    tbl[12] = '{6'b010000, 7'b0000100, 28'hFF};
    tbl[13] = '{6'b010000, 7'b0000100, 28'hFF};
    tbl[14] = '{6'b010010, 7'b0100010, 28'hFF};
    tbl[15] = '{6'b000000, 7'b0000000, 28'hFF};
    tbl[16] = '{6'b000000, 7'b0000000, 28'hFF};
    tbl[17] = '{6'b011000, 7'b0000100, 28'hFF};
    tbl[18] = '{6'b011001, 7'b0010001, 28'hFF};
    tbl[19] = '{6'b000000, 7'b0000000, 28'hFF};
    tbl[20] = '{6'b000000, 7'b0000000, 28'hFF};

    do_reset();
    ic_address_i    = 28'h0000010;
    dc_address_i    = 28'h00000FF;
    dc_write_data_i = {4{32'h1234_5678}};
    m_read_data_i   = {16{8'hA5}};
    for (int i = 0; i < 21; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Tie after reset goes to the icache. The dcache waits through RELEASE and IDLE,
    // then wins the next tie. The icache drops its enable mid-transaction and still gets its done pulse.
    do_reset();
    ic_address_i  = 28'h0000010;
    dc_address_i  = 28'h0000020;
    m_read_data_i = {4{32'hDEAD_BEEF}};
    run_vec('{6'b110000, 7'b0001100, 28'h0},  "rr0");
    run_vec('{6'b110100, 7'b0001110, 28'h10}, "rr1");
    run_vec('{6'b110100, 7'b0001110, 28'h10}, "rr2");
    run_vec('{6'b110010, 7'b1000110, 28'h10}, "rr3");
    run_vec('{6'b110000, 7'b0001100, 28'h10}, "rr4");
    run_vec('{6'b110000, 7'b0001100, 28'h10}, "rr5");
    run_vec('{6'b110100, 7'b0001110, 28'h20}, "rr6");
    run_vec('{6'b110010, 7'b0101010, 28'h20}, "rr7");
    run_vec('{6'b110000, 7'b0001100, 28'h20}, "rr8");
    run_vec('{6'b110000, 7'b0001100, 28'h20}, "rr9");
    run_vec('{6'b000010, 7'b1000010, 28'h10}, "rr10");
    run_vec('{6'b000000, 7'b0000000, 28'h10}, "rr11");

    // Assert reset asynchronously in the middle of a dcache refill.
    do_reset();
    dc_address_i = 28'h0000033;
    run_vec('{6'b010000, 7'b0000100, 28'h0},  "ar0");
    run_vec('{6'b010100, 7'b0000110, 28'h33}, "ar1");
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("ar_async_ctl", 128'(ctl), 128'(7'b0000100));
    chk("ar_async_addr", 128'(m_address_o), 128'(0));
    $display("ar async reset ctl=%b", ctl);
    @(negedge clk_i);
    set_in(6'b010010);
    #1;
    chk("ar_held_ctl", 128'(ctl), 128'(7'b0000100));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    set_in(6'b000010);
    #1;
    chk("ar_rel_ctl", 128'(ctl), 128'(7'b0000000));
    run_vec('{6'b000010, 7'b0000000, 28'h0},  "ar2");
    run_vec('{6'b010000, 7'b0000100, 28'h0},  "ar3");
    run_vec('{6'b010010, 7'b0100010, 28'h33}, "ar4");
    run_vec('{6'b000000, 7'b0000000, 28'h33}, "ar5");

    // Randomized run: a transaction-level model predicts ownership, grants and pulses.
    do_reset();
    owner = 0; last = 2; rel = 1'b0; own_wr = 1'b0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
    ic_act = 1'b0; dc_act = 1'b0; dc_wr_pick = 1'b0; dc_both = 1'b0; ntx = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (!ic_act && $urandom_range(0, 3) == 0) begin
        ic_act       = 1'b1;
        ic_address_i = 28'($urandom());
      end
      if (!dc_act && $urandom_range(0, 3) == 0) begin
        dc_act          = 1'b1;
        dc_address_i    = 28'($urandom());
        dc_wr_pick      = ($urandom_range(0, 1) == 1);
        dc_both         = ($urandom_range(0, 7) == 0);
        dc_write_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      ic_read_en_i   = ic_act;
      dc_write_en_i  = dc_act && dc_wr_pick;
      dc_read_en_i   = dc_act && (!dc_wr_pick || dc_both);
      m_busywait_i   = ($urandom_range(0, 2) == 0);
      m_read_done_i  = ($urandom_range(0, 2) == 0);
      m_write_done_i = ($urandom_range(0, 2) == 0);
      m_read_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;

      rok   = m_read_done_i && !m_busywait_i;
      wok   = m_write_done_i && !m_busywait_i;
      e_icd = (owner == 1) && rok;
      e_drd = (owner == 2) && !own_wr && rok;
      e_dwd = (owner == 2) && own_wr && wok;
      e_icb = (owner == 1) ? (m_busywait_i || !e_icd) : ic_read_en_i;
      e_dcb = (owner == 2) ? (m_busywait_i || !(e_drd || e_dwd))
                           : (dc_read_en_i || dc_write_en_i);

      chk($sformatf("rnd%0d_ctl", c), 128'(ctl),
          128'({e_icd, e_drd, e_dwd, e_icb, e_dcb, e_ren, e_wen}));
      chk($sformatf("rnd%0d_addr", c), 128'(m_address_o), 128'(e_addr));
      if (e_wen) chk($sformatf("rnd%0d_wdata", c), m_write_data_o, e_wdata);
      if (e_icd) chk($sformatf("rnd%0d_icdata", c), ic_read_data_o, m_read_data_i);
      if (e_drd) chk($sformatf("rnd%0d_dcdata", c), dc_read_data_o, m_read_data_i);

      if (owner != 0) begin
        if (e_icd || e_drd || e_dwd) begin
          ntx++;
          $display("txn %0d cycle %0d %s addr=%h", ntx, c,
                   e_icd ? "ic_read" : (e_drd ? "dc_read" : "dc_write"), e_addr);
          if (e_icd) ic_act = 1'b0;
          else       dc_act = 1'b0;
          owner = 0;
          rel   = 1'b1;
          e_ren = 1'b0;
          e_wen = 1'b0;
        end
      end else if (rel) begin
        rel = 1'b0;
      end else begin
        if (ic_read_en_i && (dc_read_en_i || dc_write_en_i)) owner = (last == 2) ? 1 : 2;
        else if (ic_read_en_i)                                owner = 1;
        else if (dc_read_en_i || dc_write_en_i)               owner = 2;
        if (owner == 1) begin
          last   = 1;
          e_ren  = 1'b1;
          e_addr = ic_address_i;
        end else if (owner == 2) begin
          last   = 2;
          e_addr = dc_address_i;
          own_wr = dc_write_en_i;
          if (dc_write_en_i) begin
            e_wen   = 1'b1;
            e_wdata = dc_write_data_i;
          end else begin
            e_ren = 1'b1;
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
